// File: rtl/reg_preload_loader_pkg.sv
// rtl/reg_preload_loader_pkg.sv - shared state encodings and widths for the register preload loader
package reg_preload_loader_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/reg_preload_loader.sv
// rtl/reg_preload_loader.sv - streams NUM_REGS words into the register file while holding the CPU
// Optional PRELOAD_CHECKSUM_EN adds an XOR checksum of the words accepted in a session.
module reg_preload_loader
    import reg_preload_loader_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 10,
    parameter int BASE_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data,
    output logic                  cpu_hold,
    output logic                  busy,
`ifdef PRELOAD_CHECKSUM_EN
    output logic [WIDTH-1:0]      checksum,
`endif
    output logic                  done
);

    localparam logic [3:0]            LAST_IDX  = 4'(NUM_REGS - 1);
    localparam logic [REG_ADDR_W-1:0] BASE_ADDR = REG_ADDR_W'(BASE_REG);

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_idx;
    logic                    r_wr_en;
    logic [REG_ADDR_W-1:0]   r_wr_addr;
    logic [WIDTH-1:0]        r_wr_data;
    logic                    w_accept;
    logic                    w_last;

    // Abort discards any word offered in the same cycle.
    assign w_accept = in_valid && (r_state == ST_LOAD) && !abort;
    assign w_last   = (r_idx == LAST_IDX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start && !abort) w_next = ST_LOAD;
            ST_LOAD: begin
                if (abort)                   w_next = ST_IDLE;
                else if (w_accept && w_last) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state <= w_next;
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= BASE_ADDR + {1'b0, r_idx};
                r_wr_data <= in_data;
            end
            // Index stays on the last slot after the final word so it never wraps.
            if (w_next == ST_IDLE)
                r_idx <= '0;
            else if (w_accept && !w_last)
                r_idx <= r_idx + 4'd1;
        end
    end

`ifdef PRELOAD_CHECKSUM_EN
    logic [WIDTH-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_checksum <= '0;
        else if (r_state == ST_IDLE && start && !abort)
            r_checksum <= '0;
        else if (w_accept)
            r_checksum <= r_checksum ^ in_data;
    end

    assign checksum = r_checksum;
`endif

    assign in_ready = (r_state == ST_LOAD);
    assign busy     = (r_state != ST_IDLE);
    assign cpu_hold = busy;
    assign done     = (r_state == ST_DONE);
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;

endmodule

// File: tb/tb_reg_preload_loader.sv
// tb/tb_reg_preload_loader.sv - scoreboard bench: default instance plus BASE_REG=20/NUM_REGS=3 instance
module tb_reg_preload_loader;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start1, abort1, in_valid1;
    logic [W-1:0]  in_data1;
    logic          in_ready1, wr_en1, cpu_hold1, busy1, done1;
    logic [4:0]    wr_addr1;
    logic [W-1:0]  wr_data1;
    logic          start2, abort2, in_valid2;
    logic [W-1:0]  in_data2;
    logic          in_ready2, wr_en2, cpu_hold2, busy2, done2;
    logic [4:0]    wr_addr2;
    logic [W-1:0]  wr_data2;
`ifdef PRELOAD_CHECKSUM_EN
    logic [W-1:0]  checksum1, checksum2;
`endif

    int n_vec = 0;
    int n_err = 0;
    int done_cnt1 = 0;
    int done_cnt2 = 0;
    logic [36:0] q1[$];
    logic [36:0] q2[$];

    always #5 clk = ~clk;

    reg_preload_loader #(.WIDTH(W), .NUM_REGS(10), .BASE_REG(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .cpu_hold(cpu_hold1), .busy(busy1),
`ifdef PRELOAD_CHECKSUM_EN
        .checksum(checksum1),
`endif
        .done(done1)
    );

    reg_preload_loader #(.WIDTH(W), .NUM_REGS(3), .BASE_REG(20)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .cpu_hold(cpu_hold2), .busy(busy2),
`ifdef PRELOAD_CHECKSUM_EN
        .checksum(checksum2),
`endif
        .done(done2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every write must match the next queued expectation.
    always @(negedge clk) begin
        if (done1) done_cnt1++;
        if (wr_en1) begin
            if (q1.size() == 0) chk("dut1_unexpected_write", {27'd0, wr_addr1, wr_data1}, 64'h0);
            else begin
                logic [36:0] e;
                e = q1.pop_front();
                chk("dut1_write", {27'd0, wr_addr1, wr_data1}, {27'd0, e});
            end
        end
    end

    always @(negedge clk) begin
        if (done2) done_cnt2++;
        if (wr_en2) begin
            if (q2.size() == 0) chk("dut2_unexpected_write", {27'd0, wr_addr2, wr_data2}, 64'h0);
            else begin
                logic [36:0] e;
                e = q2.pop_front();
                chk("dut2_write", {27'd0, wr_addr2, wr_data2}, {27'd0, e});
            end
        end
    end

    task automatic check_idle1(input string tag);
        chk({tag, "_outs1"}, {58'd0, in_ready1, wr_en1, cpu_hold1, busy1, done1, 1'b0}, 64'h0);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        start1 = 0; abort1 = 0; in_valid1 = 0; in_data1 = '0;
        start2 = 0; abort2 = 0; in_valid2 = 0; in_data2 = '0;
        tick(); tick();
        check_idle1("reset");
        chk("reset_addr_data", {27'd0, wr_addr1, wr_data1}, 64'h0);
        chk("reset_busy2", {62'd0, busy2, done2}, 64'h0);
`ifdef PRELOAD_CHECKSUM_EN
        chk("reset_checksum", {32'd0, checksum1}, 64'h0);
`endif
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a load.
        start1 = 1; tick(); start1 = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid1 = 1; in_data1 = 32'h40 + i;
            q1.push_back({5'(i), 32'h40 + i});
            tick();
        end
        rst_n = 0; tick(); tick();
        check_idle1("midload_reset");
        chk("midload_reset_addr", {59'd0, wr_addr1}, 64'h0);
        rst_n = 1; in_valid1 = 0; tick();
        start1 = 1; tick(); start1 = 0;
        in_valid1 = 1; in_data1 = 32'h55; q1.push_back({5'd0, 32'h55});
        tick();
        in_valid1 = 0; abort1 = 1; tick(); abort1 = 0; tick();
        chk("after_reset_q", q1.size(), 0);

        // Full back-to-back load.
        d0 = done_cnt1;
        start1 = 1; tick(); start1 = 0;
        chk("load_hold", {62'd0, cpu_hold1, in_ready1}, 64'h3);
        for (int i = 0; i < 10; i++) begin
            in_valid1 = 1; in_data1 = 32'h11 + i;
            q1.push_back({5'(i), 32'h11 + i});
            tick();
            if (i == 9) chk("full_done", {62'd0, done1, cpu_hold1}, 64'h3);
        end
        in_valid1 = 0; tick();
        check_idle1("full_end");
        tick();
        chk("full_done_count", done_cnt1 - d0, 1);
        chk("full_q", q1.size(), 0);

        // Gapped valid.
        d0 = done_cnt1;
        start1 = 1; tick(); start1 = 0;
        for (int k = 0; k < 20; k++) begin
            in_valid1 = (k % 2 == 0);
            in_data1 = 32'h20 + k / 2;
            if (k % 2 == 0) q1.push_back({5'(k / 2), 32'h20 + k / 2});
            tick();
        end
        in_valid1 = 0; tick();
        chk("gap_done_count", done_cnt1 - d0, 1);
        chk("gap_q", q1.size(), 0);
        chk("gap_busy", {63'd0, busy1}, 64'h0);

        // Abort after four words; valid in IDLE is ignored.
        d0 = done_cnt1;
        start1 = 1; tick(); start1 = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid1 = 1; in_data1 = 32'h30 + i;
            q1.push_back({5'(i), 32'h30 + i});
            tick();
        end
        in_data1 = 32'h34; abort1 = 1; tick(); abort1 = 0;
        chk("abort_state", {62'd0, busy1, in_ready1}, 64'h0);
        chk("abort_no_write", {63'd0, wr_en1}, 64'h0);
        in_data1 = 32'h99; tick(); tick();
        in_valid1 = 0;
        chk("abort_done_count", done_cnt1 - d0, 0);
        chk("abort_q", q1.size(), 0);

        // Offset instance: start+abort in IDLE, start while busy.
        d0 = done_cnt2;
        start2 = 1; abort2 = 1; tick(); start2 = 0; abort2 = 0;
        chk("start_abort_idle", {63'd0, busy2}, 64'h0);
        start2 = 1; tick(); start2 = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid2 = 1; in_data2 = 32'hA + i;
            start2 = (i == 1);
            q2.push_back({5'(20 + i), 32'hA + i});
            tick();
        end
        start2 = 0; in_valid2 = 0;
        chk("base_done", {62'd0, done2, cpu_hold2}, 64'h3);
        tick();
        chk("base_idle", {63'd0, busy2}, 64'h0);
        tick();
        chk("base_done_count", done_cnt2 - d0, 1);
        chk("base_q", q2.size(), 0);

`ifdef PRELOAD_CHECKSUM_EN
        start2 = 1; tick(); start2 = 0;
        begin
            logic [31:0] wv [3];
            wv[0] = 32'hF0; wv[1] = 32'h0F; wv[2] = 32'hFF;
            for (int i = 0; i < 3; i++) begin
                in_valid2 = 1; in_data2 = wv[i];
                q2.push_back({5'(20 + i), wv[i]});
                tick();
            end
        end
        in_valid2 = 0;
        chk("csum_done", {32'd0, checksum2}, 64'h0);
        tick();
        chk("csum_stable", {32'd0, checksum2}, 64'h0);
        start2 = 1; tick(); start2 = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid2 = 1; in_data2 = 32'h1 + i;
            q2.push_back({5'(20 + i), 32'h1 + i});
            tick();
        end
        in_valid2 = 0; abort2 = 1; tick(); abort2 = 0;
        chk("csum_abort", {32'd0, checksum2}, 64'h3);
        start2 = 1; tick(); start2 = 0;
        chk("csum_clear", {32'd0, checksum2}, 64'h0);
        abort2 = 1; tick(); abort2 = 0; tick();
        chk("csum_q", q2.size(), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
